nor4_response_checker: RTL and testbench

Self-running exhaustive tester for a 4-input combinational gate under test (DUT). It drives all 16 input vectors to the DUT, waits a programmable settle time, samples the DUT output, compares it against a parameterised truth table (4-input NOR by default) and reports the error count, the first failing vector and a pass/fail verdict. It is the on-board counterpart of the simulation stimulus bench for the gate labs, so the same gate can be checked in hardware with results shown on LEDs.

---
 rtl/nor4_response_checker.sv | 148 ++++++++++++++
 tb/tb_nor4_response_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/nor4_response_checker.sv
// nor4_response_checker
// Self-running exhaustive tester for a 4-input combinational gate. It sweeps
// all 16 input vectors, holds each for a settle time, samples the gate output,
// compares it against a truth table and reports the error count, the first
// failing vector and a pass/fail verdict.
module nor4_response_checker #(
  parameter int          SETTLE_CYCLES = 2,         // 1..255 cycles per vector before sampling
  parameter logic [15:0] TRUTH         = 16'h0001   // bit i = expected output for vector i (NOR)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_e,
  output logic [3:0] stim,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Last settle count value before moving to the sample cycle.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  // Expected gate response for one input vector.
  function automatic logic expected_bit(input logic [15:0] table_v, input logic [3:0] vec);
    return table_v[vec];
  endfunction

  state_t     state_r, state_s;
  logic [7:0] settle_r, settle_s;
  logic [3:0] stim_r, stim_s;
  logic [4:0] err_r, err_s;
  logic       fail_valid_r, fail_valid_s;
  logic [3:0] first_fail_r, first_fail_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       pass_r, pass_s;
  logic       mismatch_s;

  // State and result registers; synchronous reset returns everything to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      settle_r     <= 8'd0;
      stim_r       <= 4'd0;
      err_r        <= 5'd0;
      fail_valid_r <= 1'b0;
      first_fail_r <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      settle_r     <= settle_s;
      stim_r       <= stim_s;
      err_r        <= err_s;
      fail_valid_r <= fail_valid_s;
      first_fail_r <= first_fail_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
    end
  end

  // Next-state and result update logic; status flags are derived from the
  // next state so that the registered outputs line up with the state.
  always_comb begin
    state_s      = state_r;
    settle_s     = settle_r;
    stim_s       = stim_r;
    err_s        = err_r;
    fail_valid_s = fail_valid_r;
    first_fail_s = first_fail_r;
    mismatch_s   = (dut_e != expected_bit(TRUTH, stim_r));

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s      = ST_APPLY;
          stim_s       = 4'd0;
          settle_s     = 8'd0;
          err_s        = 5'd0;
          fail_valid_s = 1'b0;
          first_fail_s = 4'd0;
        end else begin
          state_s = state_r;
        end
      end

      ST_APPLY: begin
        settle_s = settle_r + 8'd1;
        if (settle_r == SETTLE_LAST) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_APPLY;
        end
      end

      ST_SAMPLE: begin
        if (mismatch_s) begin
          err_s = err_r + 5'd1;
          if (!fail_valid_r) begin
            first_fail_s = stim_r;
            fail_valid_s = 1'b1;
          end else begin
            first_fail_s = first_fail_r;
          end
        end else begin
          err_s = err_r;
        end
        if (stim_r == 4'd15) begin
          state_s = ST_DONE;
          stim_s  = 4'd0;
        end else begin
          state_s  = ST_APPLY;
          stim_s   = stim_r + 4'd1;
          settle_s = 8'd0;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_APPLY) || (state_s == ST_SAMPLE);
    done_s = (state_s == ST_DONE);
    pass_s = (state_s == ST_DONE) && (err_s == 5'd0);
  end

  assign stim       = stim_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_r;
  assign fail_valid = fail_valid_r;
  assign first_fail = first_fail_r;

endmodule

// File: tb/tb_nor4_response_checker.sv
// Self-checking bench for nor4_response_checker (SETTLE_CYCLES=2, P=3).
// The gate under test is modelled as a 16-entry response table indexed by
// stim; the reference model derives expected results directly from the
// NOR rule and cycle arithmetic.
module tb_nor4_response_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dut_e;
  logic [3:0]  stim;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic        fail_valid;
  logic [3:0]  first_fail;
  logic [15:0] gate_tt;

  int n_checks = 0;
  int n_fail   = 0;

  nor4_response_checker #(.SETTLE_CYCLES(2), .TRUTH(16'h0001)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_e      (dut_e),
    .stim       (stim),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  // Gate under test: combinational lookup on the applied vector.
  assign dut_e = gate_tt[stim];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: mismatch map of a gate table against 4-input NOR.
  task automatic model_mismatch(input logic [15:0] tt, output bit mm [16]);
    for (int v = 0; v < 16; v++) begin
      bit nor_v;
      nor_v = (v == 0);
      mm[v] = (tt[v] != nor_v);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_stim"}, stim, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_pass"}, pass, 0);
    check_val({tag, "_err"},  err_count, 0);
    check_val({tag, "_fv"},   fail_valid, 0);
    check_val({tag, "_ff"},   first_fail, 0);
  endtask

  // Start a sweep from the current cycle (cycle 0) and check every cycle up
  // to the verdict in cycle 49. Leaves the bench positioned in cycle 49.
  task automatic run_sweep(input logic [15:0] tt, input bit poke10,
                           input bit random_pokes, input bit hold);
    bit mm [16];
    int errs;
    int ff;
    bit fv;
    int k;
    gate_tt = tt;
    model_mismatch(tt, mm);
    start = 1'b1;
    next_cycle();
    for (int c = 1; c <= 49; c++) begin
      // Vectors whose comparison result is already visible in cycle c.
      k = (c - 1) / 3;
      errs = 0; ff = 0; fv = 0;
      for (int v = 0; v < k; v++) begin
        if (mm[v]) begin
          if (!fv) begin
            fv = 1;
            ff = v;
          end
          errs++;
        end
      end
      check_val("busy", busy, (c <= 48) ? 1 : 0);
      check_val("done", done, (c == 49) ? 1 : 0);
      check_val("stim", stim, (c <= 48) ? (c - 1) / 3 : 0);
      check_val("err_count", err_count, errs);
      check_val("fail_valid", fail_valid, fv);
      if (c == 49) begin
        check_val("first_fail", first_fail, ff);
        check_val("pass", pass, (errs == 0) ? 1 : 0);
      end else begin
        check_val("pass_low", pass, 0);
      end
      start = hold || (poke10 && c == 10) ||
              (random_pokes && c < 49 && $urandom_range(0, 7) == 0);
      if (c < 49) next_cycle();
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    gate_tt = 16'h0001;
    repeat (3) next_cycle();
    check_reset_values("reset");
    rst = 1'b0;
    next_cycle();

    // Correct NOR gate.
    run_sweep(16'h0001, 1'b0, 1'b0, 1'b0);
    // Results held in DONE while start stays low.
    start = 1'b0;
    repeat ($urandom_range(1, 5)) begin
      next_cycle();
      check_val("hold_done", done, 1);
      check_val("hold_pass", pass, 1);
    end

    // Stuck-at-0, started from DONE.
    run_sweep(16'h0000, 1'b0, 1'b0, 1'b0);
    // Stuck-at-1 with an ignored start pulse in cycle 10.
    run_sweep(16'hFFFF, 1'b1, 1'b0, 1'b0);
    // Correct gate restarted from a failing verdict: results must clear.
    run_sweep(16'h0001, 1'b0, 1'b0, 1'b0);
    // OR gate: every vector wrong, count reaches 16.
    run_sweep(16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Random gate tables with random ignored start pulses.
    repeat (6) begin
      run_sweep(16'($urandom), 1'b0, 1'b1, 1'b0);
    end

    // Start held high: sweep restarts right after DONE, done lasts one cycle.
    run_sweep(16'($urandom), 1'b0, 1'b0, 1'b1);
    next_cycle();
    check_val("hold_restart_busy", busy, 1);
    check_val("hold_restart_done", done, 0);
    check_val("hold_restart_stim", stim, 0);
    start = 1'b0;

    // Reset mid-sweep with a stuck-at-1 gate, asserted in cycle 20.
    rst = 1'b1;
    next_cycle();
    rst     = 1'b0;
    gate_tt = 16'hFFFF;
    start   = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < 20; c++) next_cycle();
    check_val("pre_rst_busy", busy, 1);
    rst = 1'b1;
    next_cycle();
    check_reset_values("mid_rst");
    rst = 1'b0;
    next_cycle();
    check_reset_values("post_rst_idle");
    run_sweep(16'hFFFF, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
